multicycle_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the RV32I core. It replaces per-instruction combinational control with a state machine that walks each instruction through fetch, decode, execute, memory and write-back. It issues one-cycle strobes to the PC, IR, register file and the shared instruction/data memory port, and holds the ALU, immediate and mux selects stable for the whole instruction. It sits between the IR/flag outputs of the datapath and every datapath enable.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV32I datapath.
// The slave side is the sequencer; the master side is the datapath and memory port.
interface multicycle_ctrl_if;
  logic [31:0] inst;
  logic [3:0]  stat_flag;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic        ir_we;
  logic        pc_we;
  logic        PCsrc;
  logic        RW;
  logic        WB;
  logic        ALUsrc;
  logic [3:0]  ALU_OP;
  logic [1:0]  imm_sel;
  logic [2:0]  state;
  logic        instret;
  logic        illegal;

  modport slave (
    input  inst, stat_flag, mem_ready,
    output mem_req, mem_we, mem_sel, ir_we, pc_we, PCsrc, RW, WB,
           ALUsrc, ALU_OP, imm_sel, state, instret, illegal
  );

  modport master (
    output inst, stat_flag, mem_ready,
    input  mem_req, mem_we, mem_sel, ir_we, pc_we, PCsrc, RW, WB,
           ALUsrc, ALU_OP, imm_sel, state, instret, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and write-back, issuing one-cycle strobes to the datapath.
//
// state  | meaning
// FETCH  | request instruction word, load IR/OLDPC and PC+4 on mem_ready
// DECODE | classify opcode; unknown opcodes go to TRAP
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data access for LW/SW, held until mem_ready
// WBK    | register-file write, retire
// TRAP   | illegal opcode, frozen until reset
module multicycle_ctrl (
  input logic        clk,
  input logic        rst,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WBK    = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;
  logic        w_set_illegal;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_b, w_legal;
  logic        w_dec_alusrc;
  logic [1:0]  w_dec_imm;
  logic [3:0]  w_dec_alu;
  logic        w_taken;
  logic        w_unused_bits;

  logic        w_mem_req, w_mem_we, w_mem_sel, w_ir_we, w_pc_we, w_pcsrc;
  logic        w_rw, w_wb, w_alusrc, w_instret, w_illegal;
  logic [3:0]  w_alu_op;
  logic [1:0]  w_imm_sel;
  logic [2:0]  w_state;
  logic        w_dec_en;

  assign w_opcode = bus.inst[6:0];
  assign w_funct3 = bus.inst[14:12];
  assign w_is_r   = (w_opcode == 7'b0110011);
  assign w_is_i   = (w_opcode == 7'b0010011);
  assign w_is_lw  = (w_opcode == 7'b0000011);
  assign w_is_sw  = (w_opcode == 7'b0100011);
  assign w_is_b   = (w_opcode == 7'b1100011);
  assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_b;

  assign w_unused_bits = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7],
                           bus.stat_flag[3:2]};

  // Selects are a pure function of the IR so they stay stable for the whole instruction.
  always_comb begin
    w_dec_alusrc = 1'b0;
    w_dec_imm    = 2'b00;
    w_dec_alu    = 4'b0000;
    if (w_is_r) begin
      w_dec_alu    = {bus.inst[30], w_funct3};
    end else if (w_is_i) begin
      w_dec_alusrc = 1'b1;
      w_dec_imm    = 2'b01;
      w_dec_alu    = {bus.inst[30] & (w_funct3 == 3'b101), w_funct3};
    end else if (w_is_lw) begin
      w_dec_alusrc = 1'b1;
      w_dec_imm    = 2'b01;
    end else if (w_is_sw) begin
      w_dec_alusrc = 1'b1;
      w_dec_imm    = 2'b10;
    end else if (w_is_b) begin
      w_dec_imm    = 2'b11;
      w_dec_alu    = 4'b1000;
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = bus.stat_flag[0];
      3'b001:  w_taken = ~bus.stat_flag[0];
      3'b100:  w_taken = bus.stat_flag[1];
      3'b101:  w_taken = ~bus.stat_flag[1];
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_sel     = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pcsrc       = 1'b0;
    w_rw          = 1'b0;
    w_wb          = 1'b0;
    w_instret     = 1'b0;
    w_dec_en      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_dec_en = 1'b1;
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_EXEC: begin
        w_dec_en = 1'b1;
        if (w_is_r || w_is_i) begin
          w_next = S_WBK;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else if (w_is_b) begin
          w_pc_we   = w_taken;
          w_pcsrc   = w_taken;
          w_instret = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_MEM: begin
        w_dec_en  = 1'b1;
        w_mem_req = 1'b1;
        w_mem_sel = 1'b1;
        w_mem_we  = w_is_sw;
        if (bus.mem_ready) begin
          if (w_is_sw) begin
            w_instret = 1'b1;
            w_next    = S_FETCH;
          end else begin
            w_next = S_WBK;
          end
        end
      end
      S_WBK: begin
        w_dec_en  = 1'b1;
        w_rw      = 1'b1;
        w_wb      = w_is_lw;
        w_instret = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase

    w_alusrc  = w_dec_en ? w_dec_alusrc : 1'b0;
    w_imm_sel = w_dec_en ? w_dec_imm    : 2'b00;
    w_alu_op  = w_dec_en ? w_dec_alu    : 4'b0000;
    w_state   = r_state;
    w_illegal = r_illegal;

    // Reset overrides the in-flight instruction combinationally, so no strobe leaks out.
    if (rst) begin
      w_set_illegal = 1'b0;
      w_mem_req     = 1'b0;
      w_mem_we      = 1'b0;
      w_mem_sel     = 1'b0;
      w_ir_we       = 1'b0;
      w_pc_we       = 1'b0;
      w_pcsrc       = 1'b0;
      w_rw          = 1'b0;
      w_wb          = 1'b0;
      w_instret     = 1'b0;
      w_alusrc      = 1'b0;
      w_imm_sel     = 2'b00;
      w_alu_op      = 4'b0000;
      w_state       = 3'b000;
      w_illegal     = 1'b0;
    end
  end

  assign bus.mem_req = w_mem_req;
  assign bus.mem_we  = w_mem_we;
  assign bus.mem_sel = w_mem_sel;
  assign bus.ir_we   = w_ir_we;
  assign bus.pc_we   = w_pc_we;
  assign bus.PCsrc   = w_pcsrc;
  assign bus.RW      = w_rw;
  assign bus.WB      = w_wb;
  assign bus.ALUsrc  = w_alusrc;
  assign bus.ALU_OP  = w_alu_op;
  assign bus.imm_sel = w_imm_sel;
  assign bus.state   = w_state;
  assign bus.instret = w_instret;
  assign bus.illegal = w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected memory
// completions and retirements; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_FETCH = 3'b000, ST_DECODE = 3'b001, ST_EXEC = 3'b010,
                         ST_MEM = 3'b011, ST_WBK = 3'b100, ST_TRAP = 3'b111;

  typedef struct packed {
    logic [2:0] st;
    logic       sel, we, ir_we, pc_we, pcsrc;
    logic [3:0] alu;
    logic [1:0] imm;
  } mem_t;

  typedef struct packed {
    logic [2:0] st;
    logic       rw, wb, pc_we, pcsrc, alusrc;
    logic [3:0] alu;
    logic [1:0] imm;
  } ret_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  mem_t mem_q[$];
  ret_t ret_q[$];
  int   lat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_t mk_mem(logic [2:0] st, logic sel, logic we, logic irwe,
                                  logic pcwe, logic pcsrc, logic [3:0] alu, logic [1:0] imm);
    mem_t m;
    m = {st, sel, we, irwe, pcwe, pcsrc, alu, imm};
    return m;
  endfunction

  function automatic ret_t mk_ret(logic [2:0] st, logic rw, logic wb, logic pcwe,
                                  logic pcsrc, logic alusrc, logic [3:0] alu, logic [1:0] imm);
    ret_t r;
    r = {st, rw, wb, pcwe, pcsrc, alusrc, alu, imm};
    return r;
  endfunction

  function automatic logic [19:0] all_out();
    return {bus.mem_req, bus.mem_we, bus.mem_sel, bus.ir_we, bus.pc_we, bus.PCsrc,
            bus.RW, bus.WB, bus.ALUsrc, bus.ALU_OP, bus.imm_sel, bus.state,
            bus.instret, bus.illegal};
  endfunction

  // Monitor
  int   cyc = 0;
  int   t_start = 0;
  mem_t got_m, exp_m;
  ret_t got_r, exp_r;
  int   exp_lat;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      t_start = cyc + 1;
    end else begin
      got_m = {bus.state, bus.mem_sel, bus.mem_we, bus.ir_we, bus.pc_we, bus.PCsrc,
               bus.ALU_OP, bus.imm_sel};
      got_r = {bus.state, bus.RW, bus.WB, bus.pc_we, bus.PCsrc, bus.ALUsrc,
               bus.ALU_OP, bus.imm_sel};
      check("strobe_gate",
            32'({bus.ir_we & ~(bus.mem_req & bus.mem_ready),
                 bus.RW & ~bus.instret,
                 bus.mem_we & ~bus.mem_req,
                 bus.pc_we & ~(bus.instret | (bus.mem_req & bus.mem_ready & bus.ir_we))}),
            32'd0);
      if (bus.mem_req) begin
        if (bus.mem_ready) begin
          if (mem_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mem_done: unexpected completion, state %0h", bus.state);
          end else begin
            exp_m = mem_q.pop_front();
            check("mem_done", 32'(got_m), 32'(exp_m));
          end
        end else if (mem_q.size() > 0) begin
          check("mem_hold", 32'({bus.state, bus.mem_sel, bus.mem_we}),
                32'({mem_q[0].st, mem_q[0].sel, mem_q[0].we}));
        end
      end
      if (bus.instret) begin
        if (ret_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL retire: unexpected instret, state %0h", bus.state);
        end else begin
          exp_r   = ret_q.pop_front();
          exp_lat = lat_q.pop_front();
          check("retire", 32'(got_r), 32'(exp_r));
          check("latency", 32'(cyc - t_start + 1), 32'(exp_lat));
        end
        t_start = cyc + 1;
      end
    end
  end

  // Driver
  localparam mem_t FETCH_REC = {ST_FETCH, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'b00};
  localparam mem_t NO_MEM    = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT in FETCH; returns at the start of the next FETCH.
  task automatic run(input string nm, input logic [31:0] ins, input logic [3:0] fl,
                     input int fw, input int mw, input bit noise, input bit has_mem,
                     input mem_t mrec, input ret_t rrec, input int lat);
    int w;
    logic [2:0] prev;
    bit left;
    bit done;
    w = 0;
    left = 1'b0;
    done = 1'b0;
    mem_q.push_back(FETCH_REC);
    if (has_mem) mem_q.push_back(mrec);
    ret_q.push_back(rrec);
    lat_q.push_back(lat);
    bus.inst = ins;
    bus.stat_flag = fl;
    prev = bus.state;
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.mem_req) begin
        if (w >= ((bus.state == ST_FETCH) ? fw : mw)) begin
          bus.mem_ready = 1'b1;
        end else begin
          bus.mem_ready = 1'b0;
          w++;
        end
      end else begin
        bus.mem_ready = noise;
      end
      step();
      if (bus.state != prev) w = 0;
      prev = bus.state;
      if (bus.state != ST_FETCH) left = 1'b1;
      else if (left) done = 1'b1;
    end
    bus.mem_ready = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout %s: state %0h", nm, bus.state);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.inst = 32'h0;
    bus.stat_flag = 4'h0;
    bus.mem_ready = 1'b0;
    step();
    step();
    check("reset_outputs", 32'(all_out()), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_release", 32'({bus.mem_req, bus.mem_sel, bus.state}), 32'({1'b1, 1'b0, ST_FETCH}));

    run("sub", 32'h402081B3, 4'h0, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 0, 4'b1000, 2'b00), 4);
    run("add", 32'h002081B3, 4'h0, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 0, 4'b0000, 2'b00), 4);
    run("add_fwait", 32'h002081B3, 4'h0, 2, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 0, 4'b0000, 2'b00), 6);
    run("sra", 32'h4020D1B3, 4'h0, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 0, 4'b1101, 2'b00), 4);
    run("srai", 32'h4050D093, 4'h0, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 1, 4'b1101, 2'b01), 4);
    run("addi_b30", 32'h40008093, 4'h0, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 1, 4'b0000, 2'b01), 4);
    run("lw_wait", 32'h0080A283, 4'h0, 0, 3, 1'b1, 1'b1,
        mk_mem(ST_MEM, 1, 0, 0, 0, 0, 4'b0000, 2'b01),
        mk_ret(ST_WBK, 1, 1, 0, 0, 1, 4'b0000, 2'b01), 8);
    run("sw", 32'h0050A423, 4'h0, 0, 0, 1'b0, 1'b1,
        mk_mem(ST_MEM, 1, 1, 0, 0, 0, 4'b0000, 2'b10),
        mk_ret(ST_MEM, 0, 0, 0, 0, 1, 4'b0000, 2'b10), 4);
    run("sw_wait", 32'h0050A423, 4'h0, 0, 1, 1'b1, 1'b1,
        mk_mem(ST_MEM, 1, 1, 0, 0, 0, 4'b0000, 2'b10),
        mk_ret(ST_MEM, 0, 0, 0, 0, 1, 4'b0000, 2'b10), 5);
    run("beq_t", 32'h00208463, 4'b0001, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 1, 1, 0, 4'b1000, 2'b11), 3);
    run("beq_nt", 32'h00208463, 4'b0000, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 0, 0, 0, 4'b1000, 2'b11), 3);
    run("bne_nt", 32'h00209463, 4'b0001, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 0, 0, 0, 4'b1000, 2'b11), 3);
    run("bne_t", 32'h00209463, 4'b0000, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 1, 1, 0, 4'b1000, 2'b11), 3);
    run("blt_t", 32'h0020C463, 4'b0010, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 1, 1, 0, 4'b1000, 2'b11), 3);
    run("blt_nt", 32'h0020C463, 4'b0001, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 0, 0, 0, 4'b1000, 2'b11), 3);
    run("bge_nt", 32'h0020D463, 4'b0010, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 0, 0, 0, 4'b1000, 2'b11), 3);
    run("bge_t", 32'h0020D463, 4'b0001, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 1, 1, 0, 4'b1000, 2'b11), 3);
    run("b_f3_010", 32'h0020A463, 4'b0011, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_EXEC, 0, 0, 0, 0, 0, 4'b1000, 2'b11), 3);

    // Reset while an LW sits in MEM with mem_ready asserted.
    mem_q.push_back(FETCH_REC);
    bus.inst = 32'h0080A283;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    step();
    step();
    check("lw_in_mem", 32'({bus.state, bus.mem_req}), 32'({ST_MEM, 1'b1}));
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_mid_lw_0", 32'(all_out()), 32'd0);
    step();
    check("rst_mid_lw_1", 32'(all_out()), 32'd0);
    step();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_mid_release", 32'({bus.state, bus.mem_req, bus.RW}), 32'({ST_FETCH, 1'b1, 1'b0}));
    run("add_after_rst", 32'h002081B3, 4'h0, 0, 0, 1'b0, 1'b0, NO_MEM,
        mk_ret(ST_WBK, 1, 0, 0, 0, 0, 4'b0000, 2'b00), 4);

    // Illegal opcode: DECODE then TRAP, frozen until reset.
    mem_q.push_back(FETCH_REC);
    bus.inst = 32'hFFFFFFFF;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check("ill_decode", 32'({bus.state, bus.illegal}), 32'({ST_DECODE, 1'b0}));
    step();
    check("ill_trap", 32'({bus.state, bus.illegal}), 32'({ST_TRAP, 1'b1}));
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("trap_quiet", 32'(all_out()), 32'({17'd0, ST_TRAP}) << 2 | 32'd1);
      step();
    end
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("ill_cleared", 32'({bus.illegal, bus.state, bus.mem_req}), 32'({1'b0, ST_FETCH, 1'b1}));
    rst = 1'b1;
    step();

    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("ret_q_drained", 32'(ret_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
